// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port unified memory between instruction fetch and load/store,
// with data priority, a fixed-latency access sequencer and pipeline freeze controls.
`timescale 1ns/1ps

module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              dm_read,
    input  logic              dm_write,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              PCWrite,
    output logic              IF_ID_Write,
    output logic              Pipe_Stall
);

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic                grant_dm;
    logic                lat_we;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_wdata;
    logic                if_buf_valid;
    logic                dm_req;
    logic                if_grant;
    logic                last_beat;

    assign dm_req    = dm_read | dm_write;
    assign if_grant  = if_req & ~if_buf_valid;
    assign last_beat = (state == BUSY) && (cnt == LAST);

    // NOTE: state and datapath registers use non-blocking assignments so every
    // flop samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        // NOTE: default first, so no path through the case leaves state_nxt unassigned
        // and no latch is inferred.
        state_nxt = state;
        unique case (state)
            IDLE:    if (dm_req || if_grant) state_nxt = BUSY;
            BUSY:    if (cnt == LAST)        state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_en   = 1'b0;
        mem_we   = 1'b0;
        dm_ready = 1'b0;
        unique case (state)
            BUSY: begin
                mem_en = 1'b1;
                mem_we = lat_we;
            end
            DONE:    dm_ready = grant_dm;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt          <= '0;
            grant_dm     <= 1'b0;
            lat_we       <= 1'b0;
            lat_addr     <= '0;
            lat_wdata    <= '0;
            dm_rdata     <= '0;
            if_rdata     <= '0;
            if_buf_valid <= 1'b0;
        end else begin
            if (state == IDLE) begin
                cnt <= '0;
                if (dm_req) begin
                    grant_dm  <= 1'b1;
                    lat_we    <= dm_write;
                    lat_addr  <= dm_addr;
                    lat_wdata <= dm_wdata;
                end else if (if_grant) begin
                    grant_dm  <= 1'b0;
                    lat_we    <= 1'b0;
                    lat_addr  <= if_addr;
                    lat_wdata <= dm_wdata;
                end
            end else if (state == BUSY) begin
                cnt <= cnt + CNT_W'(1);
            end

            if (last_beat && grant_dm && !lat_we) dm_rdata <= mem_rdata;
            if (last_beat && !grant_dm)           if_rdata <= mem_rdata;

            // A completed fetch is only ever set into an empty buffer, so set and
            // consume never coincide; the buffer survives any number of stall cycles.
            if (last_beat && !grant_dm) if_buf_valid <= 1'b1;
            else if (PCWrite)           if_buf_valid <= 1'b0;
        end
    end

    assign mem_addr    = lat_addr;
    assign mem_wdata   = lat_wdata;
    assign if_ready    = if_buf_valid;
    assign Pipe_Stall  = dm_req & ~dm_ready;
    assign PCWrite     = if_buf_valid & ~Pipe_Stall;
    assign IF_ID_Write = PCWrite;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares a single-port unified instruction/data memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the 5-stage pipeline.
- Data accesses have priority over fetches. A fixed-latency access sequencer drives the memory.
- Generates the pipeline freeze controls: PCWrite, IF_ID_Write and Pipe_Stall.
- Sits beside the load-use hazard logic. Its stall terms are ANDed with that logic's write enables at top level.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- LATENCY, 2, memory access cycles per transfer. Legal range is 1 to 15.

Ports:
- clk  in  1  Clock, rising edge.
- rst  in  1  Reset, asynchronous, active-low.
- if_req  in  1  IF stage wants the instruction at if_addr.
- if_addr  in  ADDR_W  Fetch address (PC).
- if_rdata  out  DATA_W  Buffered instruction.
- if_ready  out  1  if_rdata is valid.
- dm_read  in  1  MEM stage load.
- dm_write  in  1  MEM stage store.
- dm_addr  in  ADDR_W  Data address.
- dm_wdata  in  DATA_W  Store data.
- dm_rdata  out  DATA_W  Load data.
- dm_ready  out  1  Data access complete, one-cycle pulse.
- mem_en  out  1  Memory enable.
- mem_we  out  1  Memory write enable.
- mem_addr  out  ADDR_W  Memory address.
- mem_wdata  out  DATA_W  Memory write data.
- mem_rdata  in  DATA_W  Memory read data, valid in the last BUSY cycle.
- PCWrite  out  1  PC update enable.
- IF_ID_Write  out  1  IF/ID register write enable.
- Pipe_Stall  out  1  Freezes ID/EX, EX/MEM and MEM/WB.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE; cnt=0; grant_dm=0.
  - mem_en, mem_we, mem_addr and mem_wdata are 0.
  - dm_ready=0; if_buf_valid=0; if_rdata=0; dm_rdata=0.
  - Any access in flight is abandoned.
  - After reset is released, the first action is an arbitration in IDLE.
- FSM states: IDLE, BUSY, DONE.
- IDLE, arbitration:
  - If dm_read or dm_write is high: grant_dm=1 and go to BUSY.
  - Else, if if_req is high and if_buf_valid=0: grant_dm=0 and go to BUSY.
  - Else stay in IDLE.
  - On a grant, latch the address, the write data and the write flag (dm_write). cnt=0.
- BUSY:
  - mem_en=1; mem_addr, mem_wdata and mem_we come from the latched values.
  - mem_we is asserted only for a dm_write grant. If dm_read and dm_write are both high, the access is treated as a write.
  - cnt increments each cycle.
  - When cnt==LATENCY-1, capture mem_rdata and go to DONE:
    - Data grant and read: load dm_rdata.
    - Fetch grant: load if_rdata and set if_buf_valid.
  - Requester inputs are ignored while in BUSY.
- DONE:
  - Lasts one cycle. No grant is made. mem_en=0.
  - dm_ready=1 if grant_dm=1, for stores as well as loads.
  - Next state is IDLE.
- Timing:
  - A request sampled in IDLE at cycle t gives mem_en high in cycles t+1 to t+LATENCY.
  - Completion (DONE) is in cycle t+LATENCY+1.
  - Back-to-back throughput is one access per LATENCY+2 cycles.
- Stall outputs (combinational):
  - Pipe_Stall = (dm_read | dm_write) & ~dm_ready.
  - PCWrite = IF_ID_Write = if_buf_valid & ~Pipe_Stall.
  - if_ready = if_buf_valid.
- Instruction buffer:
  - if_buf_valid clears on the edge where PCWrite=1, i.e. when the instruction is consumed.
  - A fetch that completes while Pipe_Stall=1 is held in the buffer. It is never lost and never re-fetched.
  - No new fetch is granted while the buffer holds an instruction.
- Simultaneous requests in IDLE: data wins. The fetch waits and is granted in the first IDLE cycle with no data request.
- dm_rdata and if_rdata hold their values until the next capture.

Test Plan:
- LATENCY=2, fetch only. if_req=1, if_addr=0x40 in IDLE at cycle 0 -> mem_en=1 with mem_addr=0x40 in cycles 1-2; if_ready=1, PCWrite=1 and if_rdata=mem_rdata in cycle 3; if_buf_valid=0 in cycle 4.
- Load priority. dm_read=1 with dm_addr=0x100, and if_req=1, both in cycle 0 -> the data access runs first with mem_addr=0x100; Pipe_Stall=1 in cycles 0-2; dm_ready=1 and Pipe_Stall=0 in cycle 3; the fetch is granted in cycle 4 if dm_read=0.
- Store. dm_write=1, dm_addr=0x20, dm_wdata=0xDEADBEEF -> mem_we=1 and mem_wdata=0xDEADBEEF for 2 cycles; dm_ready pulses one cycle; dm_rdata is unchanged.
- Fetch held under a stall. A fetch completes while dm_read=1 -> if_buf_valid=1 and PCWrite=0 until dm_ready; PCWrite=1 exactly once; exactly one fetch is issued to memory.
- Both dm_read and dm_write high -> mem_we=1, treated as a store.
- Reset mid-operation. rst=0 in cycle 2 of BUSY -> mem_en=0 and all outputs are 0 immediately; after release, state is IDLE and a pending if_req is granted on the next edge.
